// File: rtl/seq_mag_comparator.sv
// Sequential magnitude comparator: walks the operands CHUNK bits per cycle from
// the MSB down, exits early on the first differing slice, and counts true results.
module seq_mag_comparator #(
   parameter int WIDTH = 6,
   parameter int CHUNK = 2,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       mode,
   input  logic             sgn,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             result,
   output logic             lt,
   output logic             eq,
   output logic             gt,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] match_cnt
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);
   localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [2:0]       mode_q, mode_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CHUNK-1:0] a_slice, b_slice;
   logic             pred;

   assign a_slice = a_q[WIDTH-1 -: CHUNK];
   assign b_slice = b_q[WIDTH-1 -: CHUNK];

   // Operands shift left after each equal slice so the slice under test is always at the top.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      mode_d  = mode_q;
      idx_d   = idx_q;
      lt_d    = lt_q;
      eq_d    = eq_q;
      gt_d    = gt_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a ^ (sgn ? MSB_MASK : '0);
               b_d     = b ^ (sgn ? MSB_MASK : '0);
               mode_d  = mode;
               idx_d   = '0;
               lt_d    = 1'b0;
               eq_d    = 1'b0;
               gt_d    = 1'b0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (a_slice > b_slice) begin
               gt_d    = 1'b1;
               state_d = DONE;
            end else if (a_slice < b_slice) begin
               lt_d    = 1'b1;
               state_d = DONE;
            end else if (idx_q == LAST_IDX) begin
               eq_d    = 1'b1;
               state_d = DONE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
               a_d   = a_q << CHUNK;
               b_d   = b_q << CHUNK;
            end
         end
         DONE: begin
            if (out_ready) begin
               lt_d    = 1'b0;
               eq_d    = 1'b0;
               gt_d    = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign lt        = out_valid & lt_q;
   assign eq        = out_valid & eq_q;
   assign gt        = out_valid & gt_q;

   always_comb begin
      pred = 1'b0;
      case (mode_q)
         3'd0:    pred = eq_q;
         3'd1:    pred = ~eq_q;
         3'd2:    pred = lt_q;
         3'd3:    pred = lt_q | eq_q;
         3'd4:    pred = gt_q;
         3'd5:    pred = gt_q | eq_q;
         default: pred = 1'b0;
      endcase
   end

   assign result = out_valid & pred;

   // Clear wins over a same-cycle increment; the count sticks at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_cnt) begin
         cnt_d = '0;
      end else if (out_valid && out_ready && result && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   assign match_cnt = cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         mode_q  <= '0;
         idx_q   <= '0;
         lt_q    <= 1'b0;
         eq_q    <= 1'b0;
         gt_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         mode_q  <= mode_d;
         idx_q   <= idx_d;
         lt_q    <= lt_d;
         eq_q    <= eq_d;
         gt_q    <= gt_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Self-checking bench for seq_mag_comparator (WIDTH=6, CHUNK=2, CNT_W=2):
// a behavioural model checked every cycle plus directed literal expectations.
module tb_seq_mag_comparator;

   localparam int W  = 6;
   localparam int C  = 2;
   localparam int CW = 2;

   localparam logic [2:0] M_EQ = 3'd0, M_NE = 3'd1, M_LT = 3'd2,
                          M_LE = 3'd3, M_GT = 3'd4, M_GE = 3'd5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid, in_ready;
   logic [W-1:0]  a, b;
   logic [2:0]    mode;
   logic          sgn;
   logic          out_valid, out_ready;
   logic          result, lt, eq, gt;
   logic          clr_cnt;
   logic [CW-1:0] match_cnt;

   int tests = 0;
   int fails = 0;

   seq_mag_comparator #(.WIDTH(W), .CHUNK(C), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .mode(mode), .sgn(sgn), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .lt(lt), .eq(eq), .gt(gt),
      .clr_cnt(clr_cnt), .match_cnt(match_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: relation by plain integer compare, latency from the highest differing bit.
   function automatic int expLatency(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W-1:0] d;
      int p;
      d = x ^ y;
      p = -1;
      for (int i = 0; i < W; i++) if (d[i]) p = i;
      if (p < 0) return W / C;
      return (W / C) - (p / C);
   endfunction

   function automatic int relOf(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      if (s) begin
         if ($signed(x) < $signed(y)) return 0;
         if ($signed(x) > $signed(y)) return 2;
         return 1;
      end
      if (x < y) return 0;
      if (x > y) return 2;
      return 1;
   endfunction

   function automatic logic predOf(input logic [2:0] m, input int r);
      case (m)
         3'd0: return r == 1;
         3'd1: return r != 1;
         3'd2: return r == 0;
         3'd3: return r <= 1;
         3'd4: return r == 2;
         3'd5: return r >= 1;
         default: return 1'b0;
      endcase
   endfunction

   int            m_phase;
   int            m_remain;
   logic          m_lt, m_eq, m_gt, m_res;
   logic [CW-1:0] m_cnt;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase  <= 0;
         m_remain <= 0;
         m_lt     <= 1'b0;
         m_eq     <= 1'b0;
         m_gt     <= 1'b0;
         m_res    <= 1'b0;
         m_cnt    <= '0;
      end else begin
         if (clr_cnt) m_cnt <= '0;
         else if (m_phase == 2 && out_ready && m_res && m_cnt != '1) m_cnt <= m_cnt + 1'b1;
         case (m_phase)
            0: if (in_valid) begin
               m_phase  <= 1;
               m_remain <= expLatency(a, b);
               m_lt     <= relOf(a, b, sgn) == 0;
               m_eq     <= relOf(a, b, sgn) == 1;
               m_gt     <= relOf(a, b, sgn) == 2;
               m_res    <= predOf(mode, relOf(a, b, sgn));
            end
            1: begin
               m_remain <= m_remain - 1;
               if (m_remain == 1) m_phase <= 2;
            end
            default: if (out_ready) m_phase <= 0;
         endcase
      end
   end

   // Every cycle out of reset, all outputs must agree with the model.
   always @(negedge clk) begin
      logic [5+CW:0] expv, actv;
      if (rst_n) begin
         expv = {m_phase == 0, m_phase == 2,
                 (m_phase == 2) ? {m_res, m_lt, m_eq, m_gt} : 4'b0000, m_cnt};
         actv = {in_ready, out_valid, result, lt, eq, gt, match_cnt};
         tests++;
         if (actv !== expv) begin
            fails++;
            $display("[TB] FAIL cycle_model t=%0t got=%b want=%b", $time, actv, expv);
         end
      end
   end

   task automatic checkOutput(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s got=%0d want=%0d", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                input logic [2:0] tm, input logic ts);
      @(negedge clk);
      a = ta; b = tb_; mode = tm; sgn = ts; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic waitResult(input string name, input int eLat, input logic eLt,
                             input logic eEq, input logic eGt, input logic eRes);
      int lat;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      checkOutput({name, "_latency"}, lat, eLat);
      checkOutput({name, "_rel"}, {lt, eq, gt}, {eLt, eEq, eGt});
      checkOutput({name, "_result"}, result, eRes);
   endtask

   task automatic releaseResult(input string name, input logic clr, input logic [CW-1:0] eCnt);
      out_ready = 1'b1;
      clr_cnt   = clr;
      @(negedge clk);
      out_ready = 1'b0;
      clr_cnt   = 1'b0;
      checkOutput({name, "_idle"}, {in_ready, out_valid}, 2'b10);
      checkOutput({name, "_cnt"}, match_cnt, eCnt);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [W-1:0] eqOps [5];
      logic [CW-1:0] eqCnt [5];
      eqOps = '{6'b101010, 6'b111111, 6'b000111, 6'b110000, 6'b011001};
      eqCnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; mode = '0; sgn = 1'b0;
      out_ready = 1'b0; clr_cnt = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      checkOutput("reset_state", {in_ready, out_valid, result, lt, eq, gt, match_cnt},
                  {2'b10, 4'b0000, 2'b00});
      rst_n = 1'b1;

      applyStimulus(6'b000000, 6'b000000, M_EQ, 1'b0);
      waitResult("eq_zero", 3, 0, 1, 0, 1);
      releaseResult("eq_zero", 1'b0, 2'd1);

      applyStimulus(6'b000001, 6'b000010, M_NE, 1'b0);
      waitResult("ne_1_2", 3, 1, 0, 0, 1);
      releaseResult("ne_1_2", 1'b0, 2'd2);

      applyStimulus(6'b000001, 6'b000010, M_GE, 1'b0);
      waitResult("ge_1_2", 3, 1, 0, 0, 0);
      releaseResult("ge_1_2", 1'b0, 2'd2);

      applyStimulus(6'b100000, 6'b000001, M_GT, 1'b0);
      waitResult("gt_unsigned", 1, 0, 0, 1, 1);
      releaseResult("gt_unsigned", 1'b0, 2'd3);

      applyStimulus(6'b100000, 6'b000001, M_GT, 1'b1);
      waitResult("gt_signed", 1, 1, 0, 0, 0);
      releaseResult("gt_signed", 1'b0, 2'd3);

      applyStimulus(6'b100000, 6'b000001, M_GT, 1'b0);
      waitResult("hold", 1, 0, 0, 1, 1);
      for (int i = 0; i < 5; i++) begin
         in_valid = ~in_valid;
         a = 6'(i * 11 + 3);
         b = 6'(i * 5);
         @(negedge clk);
         checkOutput("hold_stable", {out_valid, result, lt, eq, gt, in_ready}, 6'b110010);
      end
      in_valid = 1'b0;
      releaseResult("hold", 1'b0, 2'd3);

      @(negedge clk);
      clr_cnt = 1'b1;
      @(negedge clk);
      clr_cnt = 1'b0;
      checkOutput("clr_idle", match_cnt, 0);

      for (int i = 0; i < 5; i++) begin
         applyStimulus(eqOps[i], eqOps[i], M_EQ, 1'(i % 2));
         waitResult("eq_match", 3, 0, 1, 0, 1);
         releaseResult("eq_match", 1'b0, eqCnt[i]);
      end

      applyStimulus(6'b010101, 6'b010101, M_EQ, 1'b0);
      waitResult("clr_on_match", 3, 0, 1, 0, 1);
      releaseResult("clr_on_match", 1'b1, 2'd0);

      applyStimulus(6'b000100, 6'b001000, 3'd6, 1'b0);
      waitResult("reserved", 2, 1, 0, 0, 0);
      releaseResult("reserved", 1'b0, 2'd0);

      applyStimulus(6'b000000, 6'b000000, M_EQ, 1'b0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 checkOutput("reset_busy", {in_ready, out_valid, match_cnt}, {2'b10, 2'b00});
      @(negedge clk);
      #2 rst_n = 1'b1;

      applyStimulus(6'b010011, 6'b010110, M_LE, 1'b1);
      waitResult("after_reset", 2, 1, 0, 0, 1);
      releaseResult("after_reset", 1'b0, 2'd1);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
